// File: rtl/pixel_mixer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ppu_mix_pkg
// Purpose  : Shared types and constants for the PPU pixel mixer.
// Revision : 1.0 - initial release
// ============================================================================
package ppu_mix_pkg;

  localparam int SCREEN_WIDTH = 320;

  typedef enum logic [1:0] {
    LAYER_BG  = 2'd0,
    LAYER_FG  = 2'd1,
    LAYER_SPR = 2'd2
  } layer_t;

  typedef struct packed {
    logic [4:0] palette;
    logic [3:0] color;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    MIX   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Color index 0 is transparent on every layer.
  function automatic logic is_opaque(input pixel_t p);
    return p.color != 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_mixer_if.sv
`default_nettype none
// ============================================================================
// Interface : pixel_mixer_if
// Purpose   : Layer-engine, palette-RAM and line-buffer signals of the mixer.
// Revision  : 1.0 - initial release
// ============================================================================
interface pixel_mixer_if;

  logic        bgr_done;
  logic        fgr_done;
  logic        spr_done;
  logic [8:0]  pmxr_pixel_addr;
  logic [8:0]  bgr_pixel_data;
  logic [8:0]  fgr_pixel_data;
  logic [8:0]  spr_pixel_data;
  logic [1:0]  spr_pixel_prio;
  logic [10:0] palram_addr;
  logic [23:0] palram_rddata;
  logic [8:0]  lbuf_wraddr;
  logic [23:0] lbuf_wrdata;
  logic        lbuf_wren;

  modport master (
    input  bgr_done, fgr_done, spr_done,
    input  bgr_pixel_data, fgr_pixel_data, spr_pixel_data, spr_pixel_prio,
    input  palram_rddata,
    output pmxr_pixel_addr, palram_addr,
    output lbuf_wraddr, lbuf_wrdata, lbuf_wren
  );

  modport slave (
    output bgr_done, fgr_done, spr_done,
    output bgr_pixel_data, fgr_pixel_data, spr_pixel_data, spr_pixel_prio,
    output palram_rddata,
    input  pmxr_pixel_addr, palram_addr,
    input  lbuf_wraddr, lbuf_wrdata, lbuf_wren
  );

endinterface
`default_nettype wire

// File: rtl/pixel_mixer_layer_select.sv
`default_nettype none
// ============================================================================
// Module   : pmxr_layer_select
// Purpose  : Picks the topmost opaque layer for one pixel (combinational).
// Revision : 1.0 - initial release
// ============================================================================
module pmxr_layer_select
  import ppu_mix_pkg::*;
(
  input  pixel_t     bgr_pixel,
  input  pixel_t     fgr_pixel,
  input  pixel_t     spr_pixel,
  input  logic [1:0] spr_prio,
  output layer_t     win_layer,
  output pixel_t     win_pixel,
  output logic       win_backdrop
);

  logic w_spr_opaque;
  assign w_spr_opaque = is_opaque(spr_pixel);

  // Sprite slots in the stack: above FG (prio 2/3), between FG and BG (1), under BG (0).
  always_comb begin
    win_layer    = LAYER_BG;
    win_pixel    = '0;
    win_backdrop = 1'b0;
    if (spr_prio >= 2'd2 && w_spr_opaque) begin
      win_layer = LAYER_SPR;
      win_pixel = spr_pixel;
    end else if (is_opaque(fgr_pixel)) begin
      win_layer = LAYER_FG;
      win_pixel = fgr_pixel;
    end else if (spr_prio == 2'd1 && w_spr_opaque) begin
      win_layer = LAYER_SPR;
      win_pixel = spr_pixel;
    end else if (is_opaque(bgr_pixel)) begin
      win_layer = LAYER_BG;
      win_pixel = bgr_pixel;
    end else if (spr_prio == 2'd0 && w_spr_opaque) begin
      win_layer = LAYER_SPR;
      win_pixel = spr_pixel;
    end else begin
      win_backdrop = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_mixer
// Purpose  : Mixes BG/FG/sprite layers of one row through the palette RAM
//            into the line buffer, one pixel per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_mixer
  import ppu_mix_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prep,
  input  logic [23:0]   backdrop_color,
  output logic          done,
  pixel_mixer_if.master bus
);

  localparam logic [8:0] c_LAST_COL   = 9'(SCREEN_WIDTH - 1);
  localparam logic [1:0] c_DRAIN_LAST = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_prep;
  logic        w_prep_edge;
  logic        w_all_ready;
  logic [8:0]  r_col;
  logic [1:0]  r_drain_cnt;

  // Stage 1: sampled engine data
  logic        r_s1_valid;
  logic [8:0]  r_s1_col;
  pixel_t      r_s1_bgr;
  pixel_t      r_s1_fgr;
  pixel_t      r_s1_spr;
  logic [1:0]  r_s1_prio;

  // Stage 2: palette lookup
  logic        r_s2_valid;
  logic [8:0]  r_s2_col;
  logic        r_s2_backdrop;
  logic [10:0] r_palram_addr;

  // Stage 3: line-buffer write
  logic        r_wren;
  logic [8:0]  r_wraddr;
  logic [23:0] r_wrdata;

  layer_t      w_win_layer;
  pixel_t      w_win_pixel;
  logic        w_win_backdrop;

  assign w_prep_edge = prep & ~r_last_prep;
  assign w_all_ready = bus.bgr_done & bus.fgr_done & bus.spr_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last_prep <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last_prep <= prep;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = IDLE;
      WAIT:    if (w_all_ready) w_state_nxt = MIX;
      MIX:     if (r_col == c_LAST_COL) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain_cnt == c_DRAIN_LAST) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_prep_edge) w_state_nxt = WAIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_drain_cnt <= '0;
    end else if (w_prep_edge) begin
      r_col       <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (r_state == MIX && r_col != c_LAST_COL) r_col <= r_col + 9'd1;
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
    end
  end

  pmxr_layer_select u_layer_select (
    .bgr_pixel    (r_s1_bgr),
    .fgr_pixel    (r_s1_fgr),
    .spr_pixel    (r_s1_spr),
    .spr_prio     (r_s1_prio),
    .win_layer    (w_win_layer),
    .win_pixel    (w_win_pixel),
    .win_backdrop (w_win_backdrop)
  );

  // A prep edge kills every in-flight column so an aborted row never writes again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid    <= 1'b0;
      r_s1_col      <= '0;
      r_s1_bgr      <= '0;
      r_s1_fgr      <= '0;
      r_s1_spr      <= '0;
      r_s1_prio     <= '0;
      r_s2_valid    <= 1'b0;
      r_s2_col      <= '0;
      r_s2_backdrop <= 1'b0;
      r_palram_addr <= '0;
      r_wren        <= 1'b0;
      r_wraddr      <= '0;
      r_wrdata      <= '0;
    end else begin
      r_s1_valid <= (r_state == MIX) & ~w_prep_edge;
      r_s1_col   <= r_col;
      r_s1_bgr   <= pixel_t'(bus.bgr_pixel_data);
      r_s1_fgr   <= pixel_t'(bus.fgr_pixel_data);
      r_s1_spr   <= pixel_t'(bus.spr_pixel_data);
      r_s1_prio  <= bus.spr_pixel_prio;

      r_s2_valid <= r_s1_valid & ~w_prep_edge;
      if (r_s1_valid) begin
        r_s2_col      <= r_s1_col;
        r_s2_backdrop <= w_win_backdrop;
        r_palram_addr <= {w_win_layer, w_win_pixel};
      end

      r_wren <= r_s2_valid & ~w_prep_edge;
      if (r_s2_valid) begin
        r_wraddr <= r_s2_col;
        r_wrdata <= r_s2_backdrop ? backdrop_color : bus.palram_rddata;
      end
    end
  end

  assign bus.pmxr_pixel_addr = (r_state == MIX) ? r_col : 9'd0;
  assign bus.palram_addr     = r_palram_addr;
  assign bus.lbuf_wren       = r_wren;
  assign bus.lbuf_wraddr     = r_wraddr;
  assign bus.lbuf_wrdata     = r_wrdata;
  assign done                = (r_state == IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_mixer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_mixer
// Purpose  : Self-checking bench for pixel_mixer against a layer-stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_mixer;

  localparam int c_WIDTH = 320;

  logic        clk;
  logic        rst_n;
  logic        prep;
  logic        done;
  logic [23:0] backdrop_color;

  logic [8:0]  bg_mem [512];
  logic [8:0]  fg_mem [512];
  logic [8:0]  sp_mem [512];
  logic [1:0]  pr_mem [512];

  int n_checks = 0;
  int n_fail   = 0;

  pixel_mixer_if bus();

  pixel_mixer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prep           (prep),
    .backdrop_color (backdrop_color),
    .done           (done),
    .bus            (bus)
  );

  function automatic logic [23:0] pal_rgb(input logic [10:0] a);
    return {a[7:0], ~a[10:3], a[10:3] ^ 8'h5A};
  endfunction

  // Engines answer combinationally for the requested column; palette RAM is read-through.
  assign bus.bgr_pixel_data = bg_mem[bus.pmxr_pixel_addr];
  assign bus.fgr_pixel_data = fg_mem[bus.pmxr_pixel_addr];
  assign bus.spr_pixel_data = sp_mem[bus.pmxr_pixel_addr];
  assign bus.spr_pixel_prio = pr_mem[bus.pmxr_pixel_addr];
  assign bus.palram_rddata  = pal_rgb(bus.palram_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Build the visible stack top-first, then take the first opaque entry.
  function automatic void ref_pixel(input logic [8:0] bg, input logic [8:0] fg,
                                    input logic [8:0] sp, input logic [1:0] pr,
                                    output logic [10:0] pa, output bit bd);
    logic [8:0] stack[$];
    logic [1:0] code[$];
    if (pr >= 2'd2) begin stack.push_back(sp); code.push_back(2'd2); end
    stack.push_back(fg); code.push_back(2'd1);
    if (pr == 2'd1) begin stack.push_back(sp); code.push_back(2'd2); end
    stack.push_back(bg); code.push_back(2'd0);
    if (pr == 2'd0) begin stack.push_back(sp); code.push_back(2'd2); end
    pa = '0;
    bd = 1'b1;
    foreach (stack[i]) begin
      if (bd && stack[i][3:0] != 4'd0) begin
        pa = {code[i], stack[i]};
        bd = 1'b0;
      end
    end
  endfunction

  function automatic logic [8:0] rand_pix();
    logic [3:0] c;
    c = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    return {5'($urandom_range(0, 31)), c};
  endfunction

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check_val("idle_wren", 32'(bus.lbuf_wren), 32'd0);
      check_val("idle_done", 32'(done), 32'd1);
      check_val("idle_addr", 32'(bus.pmxr_pixel_addr), 32'd0);
    end
  endtask

  // mode 0: random layers, 1: all transparent, 2: constant bgv/fgv/spv/pv on every column.
  task automatic mix_row(input int mode, input logic [8:0] bgv, input logic [8:0] fgv,
                         input logic [8:0] spv, input logic [1:0] pv,
                         input bit use_const, input logic [10:0] pa_const,
                         input int spr_wait, input int cut_col, input bit cut_rst,
                         input bit prep_hold, input logic [23:0] bd_color);
    logic [10:0] epa  [c_WIDTH];
    bit          ebd  [c_WIDTH];
    logic [23:0] ergb [c_WIDTH];
    int m, col, exp_addr;
    bit wr_exp;
    for (int c = 0; c < 512; c++) begin
      if (mode == 0 && c < c_WIDTH) begin
        bg_mem[c] = rand_pix(); fg_mem[c] = rand_pix(); sp_mem[c] = rand_pix();
        pr_mem[c] = 2'($urandom_range(0, 3));
      end else if (mode == 2 && c < c_WIDTH) begin
        bg_mem[c] = bgv; fg_mem[c] = fgv; sp_mem[c] = spv; pr_mem[c] = pv;
      end else begin
        bg_mem[c] = '0; fg_mem[c] = '0; sp_mem[c] = '0; pr_mem[c] = '0;
      end
    end
    for (int c = 0; c < c_WIDTH; c++) begin
      ref_pixel(bg_mem[c], fg_mem[c], sp_mem[c], pr_mem[c], epa[c], ebd[c]);
      ergb[c] = ebd[c] ? bd_color : pal_rgb(epa[c]);
    end
    backdrop_color = bd_color;
    prep = 1'b1;
    bus.bgr_done = 1'b0; bus.fgr_done = 1'b0; bus.spr_done = 1'b0;
    // Edge in cycle 0, WAIT from cycle 1, MIX the cycle after spr_done rises.
    m = 2 + spr_wait;
    for (int cyc = 0; cyc <= m + 323; cyc++) begin
      if (cyc >= 1) begin
        prep = prep_hold;
        bus.bgr_done = 1'b1;
        bus.fgr_done = 1'b1;
      end
      if (cyc >= 1 + spr_wait) bus.spr_done = 1'b1;
      if (cyc >= 1) begin
        exp_addr = (cyc >= m && cyc <= m + 319) ? cyc - m : 0;
        check_val("pixel_addr", 32'(bus.pmxr_pixel_addr), 32'(exp_addr));
        check_val("done", 32'(done), (cyc >= m + 323) ? 32'd1 : 32'd0);
        wr_exp = (cyc >= m + 3 && cyc <= m + 322);
        check_val("lbuf_wren", 32'(bus.lbuf_wren), wr_exp ? 32'd1 : 32'd0);
        if (wr_exp) begin
          col = cyc - m - 3;
          check_val("lbuf_wraddr", 32'(bus.lbuf_wraddr), 32'(col));
          check_val("lbuf_wrdata", 32'(bus.lbuf_wrdata), 32'(ergb[col]));
        end
        if (cyc >= m + 2 && cyc <= m + 321) begin
          col = cyc - m - 2;
          if (!ebd[col]) check_val("palram_addr", 32'(bus.palram_addr), 32'(epa[col]));
          if (use_const && col == 0) check_val("palram_const", 32'(bus.palram_addr), 32'(pa_const));
        end
      end
      if (cut_col >= 0 && cyc == m + cut_col) begin
        if (cut_rst) begin
          rst_n = 1'b0;
          #1;
          check_val("rst_wren", 32'(bus.lbuf_wren), 32'd0);
          check_val("rst_addr", 32'(bus.pmxr_pixel_addr), 32'd0);
          check_val("rst_palram", 32'(bus.palram_addr), 32'd0);
          check_val("rst_wraddr", 32'(bus.lbuf_wraddr), 32'd0);
          check_val("rst_wrdata", 32'(bus.lbuf_wrdata), 32'd0);
          check_val("rst_done", 32'(done), 32'd1);
          prep = 1'b0;
          repeat (2) @(posedge clk);
          #1;
          rst_n = 1'b1;
          idle_cycles(12);
        end
        return;
      end
      if (cyc < m + 323) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    prep = 1'b0;
    backdrop_color = 24'h0;
    bus.bgr_done = 1'b0; bus.fgr_done = 1'b0; bus.spr_done = 1'b0;
    for (int c = 0; c < 512; c++) begin
      bg_mem[c] = '0; fg_mem[c] = '0; sp_mem[c] = '0; pr_mem[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_done", 32'(done), 32'd1);
    check_val("reset_addr", 32'(bus.pmxr_pixel_addr), 32'd0);
    check_val("reset_palram", 32'(bus.palram_addr), 32'd0);
    check_val("reset_wren", 32'(bus.lbuf_wren), 32'd0);
    check_val("reset_wraddr", 32'(bus.lbuf_wraddr), 32'd0);
    check_val("reset_wrdata", 32'(bus.lbuf_wrdata), 32'd0);
    rst_n = 1'b1;
    idle_cycles(3);

    // All transparent: every column takes the backdrop.
    mix_row(1, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 0, -1, 1'b0, 1'b0, 24'h123456);
    idle_cycles(2);

    // Fixed stacks exercising each priority slot.
    mix_row(2, 9'h021, 9'h0A5, 9'h1F3, 2'd1, 1'b1, {2'd1, 5'h0A, 4'd5}, 0, -1, 1'b0, 1'b0, 24'hABCDEF);
    mix_row(2, 9'h021, 9'h0A5, 9'h1F3, 2'd2, 1'b1, {2'd2, 5'h1F, 4'd3}, 0, -1, 1'b0, 1'b0, 24'hABCDEF);
    mix_row(2, 9'h021, 9'h000, 9'h1F3, 2'd0, 1'b1, {2'd0, 5'h02, 4'd1}, 0, -1, 1'b0, 1'b0, 24'hABCDEF);

    // Sprite engine late by 10 cycles.
    mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 10, -1, 1'b0, 1'b0, 24'h00FF00);

    // Re-prep at column 150, then a complete row.
    mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 0, 150, 1'b0, 1'b0, 24'h111111);
    mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 0, -1, 1'b0, 1'b0, 24'h222222);

    // Reset at column 200.
    mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 0, 200, 1'b1, 1'b0, 24'h333333);

    for (int r = 0; r < 3; r++) begin
      mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, int'($urandom_range(0, 5)), -1, 1'b0, 1'b0,
              24'($urandom));
      idle_cycles(int'($urandom_range(0, 3)));
    end

    // prep held high for 1000 cycles yields one row only.
    mix_row(0, 9'h0, 9'h0, 9'h0, 2'd0, 1'b0, 11'h0, 0, -1, 1'b0, 1'b1, 24'h444444);
    idle_cycles(1000 - 325);
    prep = 1'b0;
    idle_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
